// File: rtl/systolic_feeder.sv
// systolic_feeder
// Transmit-side edge driver for an N x N PE systolic array. Holds operand
// matrices A and B and, for each start command, pulses an accumulator clear,
// streams A into the array's left edge and B into its top edge with a
// diagonal skew, waits for the wavefront to drain, then pulses done.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (aborts any product in flight)
//   wr_en     load strobe for one matrix element (honoured only when idle)
//   wr_sel    0 selects matrix A, 1 selects matrix B
//   wr_row    element row index
//   wr_col    element column index
//   wr_data   element value
//   start     begin a product (sampled only when idle)
//   left_out  lane i drives left_in of array row i
//   top_out   lane j drives top_in of array column j
//   acc_clr   one-cycle pulse clearing the PE accumulators
//   busy      high from start acceptance until done
//   done      one-cycle pulse once every PE result is final

module systolic_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic                    wr_sel,
    input  logic [$clog2(N)-1:0]    wr_row,
    input  logic [$clog2(N)-1:0]    wr_col,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    start,
    output logic [N*DATA_WIDTH-1:0] left_out,
    output logic [N*DATA_WIDTH-1:0] top_out,
    output logic                    acc_clr,
    output logic                    busy,
    output logic                    done
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(3 * N);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CW-1:0] FEED_LAST  = CW'(2 * N - 2);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(N - 1);

    logic [DATA_WIDTH-1:0]   a_q [N][N];
    logic [DATA_WIDTH-1:0]   b_q [N][N];

    logic [2:0]              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [N*DATA_WIDTH-1:0] left_q, left_d;
    logic [N*DATA_WIDTH-1:0] top_q, top_d;
    logic                    acc_clr_q, busy_q, done_q;

    // Sequencer next state. The counter holds the feed time t in FEED and
    // the number of elapsed drain cycles in DRAIN; it restarts at 0 on entry
    // to each of those states so it never has to exceed 2N-2.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                cnt_d   = '0;
            end
            S_FEED: begin
                if (cnt_q == FEED_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Lane values for the coming cycle. Row i sees A[i][t-i] and column j
    // sees B[t-j][j]; outside the skewed diagonal band, and in every state
    // other than FEED, the lanes carry 0 so no stray products accumulate.
    always_comb begin
        int k;
        k      = 0;
        left_d = '0;
        top_d  = '0;
        if (state_d == S_FEED) begin
            for (int i = 0; i < N; i++) begin
                k = int'(cnt_d) - i;
                if (k >= 0 && k < N) begin
                    left_d[i*DATA_WIDTH +: DATA_WIDTH] = a_q[i][k[IW-1:0]];
                    top_d[i*DATA_WIDTH +: DATA_WIDTH]  = b_q[k[IW-1:0]][i];
                end
            end
        end
    end

    // Operand storage. Writes are honoured only while idle so the matrices
    // stay stable for the whole product; a write in the same cycle as start
    // lands before the first feed cycle reads it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_q[r][c] <= '0;
                    b_q[r][c] <= '0;
                end
            end
        end else if (wr_en && state_q == S_IDLE) begin
            if (wr_sel) begin
                b_q[wr_row][wr_col] <= wr_data;
            end else begin
                a_q[wr_row][wr_col] <= wr_data;
            end
        end
    end

    // State, counter and registered outputs. Outputs are derived from the
    // next state so each one is valid in the same cycle as its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            left_q    <= '0;
            top_q     <= '0;
            acc_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            left_q    <= left_d;
            top_q     <= top_d;
            acc_clr_q <= (state_d == S_CLEAR);
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
        end
    end

    assign left_out = left_q;
    assign top_out  = top_q;
    assign acc_clr  = acc_clr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder
// Self-checking bench for systolic_feeder (N=4, DATA_WIDTH=8). A reference
// model holds the matrices and derives the expected lane contents and the
// control timeline of each product; a behavioural 4x4 PE grid sits on the
// feeder outputs so end-to-end results can be compared with A*B.

module tb_systolic_feeder;

    localparam int DW       = 8;
    localparam int N        = 4;
    localparam int IW       = $clog2(N);
    localparam int BUSY_LEN = 3 * N + 1;
    localparam int FEED_LEN = 2 * N - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en;
    logic            wr_sel;
    logic [IW-1:0]   wr_row;
    logic [IW-1:0]   wr_col;
    logic [DW-1:0]   wr_data;
    logic            start;
    logic [N*DW-1:0] left_out;
    logic [N*DW-1:0] top_out;
    logic            acc_clr;
    logic            busy;
    logic            done;

    int testsRun    = 0;
    int testsFailed = 0;

    int refA [N][N];
    int refB [N][N];
    int capLeft [FEED_LEN][N];
    int capTop  [FEED_LEN][N];

    int peA   [N][N];
    int peB   [N][N];
    int peAcc [N][N];

    int cycleNum  = 0;
    int busyCount = 0;
    int doneCount = 0;
    int doneTimes [$];

    systolic_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_row   (wr_row),
        .wr_col   (wr_col),
        .wr_data  (wr_data),
        .start    (start),
        .left_out (left_out),
        .top_out  (top_out),
        .acc_clr  (acc_clr),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter used to time stamp done pulses.
    always @(posedge clk) cycleNum++;

    // Independent observers of busy width and done pulses.
    always @(negedge clk) begin
        if (busy === 1'b1) busyCount++;
        if (done === 1'b1) begin
            doneCount++;
            doneTimes.push_back(cycleNum);
        end
    end

    // Behavioural PE grid: operands hop one PE right/down per cycle and each
    // PE accumulates the product of the operands arriving at it.
    always @(posedge clk) begin
        int inA, inB;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                inA = (j == 0) ? int'(left_out[i*DW +: DW]) : peA[i][j-1];
                inB = (i == 0) ? int'(top_out[j*DW +: DW])  : peB[i-1][j];
                peA[i][j]   <= inA;
                peB[i][j]   <= inB;
                peAcc[i][j] <= (acc_clr === 1'b1) ? 0 : peAcc[i][j] + inA * inB;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                refA[i][j] = 0;
                refB[i][j] = 0;
            end
    endtask

    task automatic write_elem(input bit sel, input int r, input int c, input int v);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = IW'(r);
        wr_col  = IW'(c);
        wr_data = DW'(v);
        tick();
        wr_en = 1'b0;
        if (sel) refB[r][c] = v;
        else     refA[r][c] = v;
    endtask

    // Expected lane vector at feed time t; zero outside the feed window.
    function automatic logic [N*DW-1:0] exp_lanes(input bit isTop, input int t);
        logic [N*DW-1:0] v;
        int k;
        v = '0;
        if (t >= 0 && t <= 2 * N - 2) begin
            for (int lane = 0; lane < N; lane++) begin
                k = t - lane;
                if (k >= 0 && k < N)
                    v[lane*DW +: DW] = isTop ? DW'(refB[k][lane]) : DW'(refA[lane][k]);
            end
        end
        return v;
    endfunction

    // Checks one product, entered #1 after the edge that accepted start.
    task automatic check_product(input bit injWrite, input bit injStart,
                                 input bit holdStart, input bit checkPe);
        logic [2:0]      expCtl;
        logic [2:0]      gotCtl;
        logic [N*DW-1:0] expL;
        logic [N*DW-1:0] expT;
        int t, busyStart, doneStart, expAcc;
        busyStart = busyCount;
        doneStart = doneCount;
        if (!holdStart) start = 1'b0;
        for (int c = 1; c <= BUSY_LEN; c++) begin
            t      = c - 2;
            expCtl = {c == 1, 1'b1, c == BUSY_LEN};
            gotCtl = {acc_clr, busy, done};
            testsRun++;
            if (gotCtl !== expCtl) begin
                testsFailed++;
                $display("[TB] FAIL ctl cycle %0d: {acc_clr,busy,done} got %b expected %b", c, gotCtl, expCtl);
            end
            expL = exp_lanes(1'b0, t);
            expT = exp_lanes(1'b1, t);
            testsRun++;
            if (left_out !== expL || top_out !== expT) begin
                testsFailed++;
                $display("[TB] FAIL lanes cycle %0d: left %h top %h expected left %h top %h",
                         c, left_out, top_out, expL, expT);
            end
            if (t >= 0 && t < FEED_LEN) begin
                for (int i = 0; i < N; i++) begin
                    capLeft[t][i] = int'(left_out[i*DW +: DW]);
                    capTop[t][i]  = int'(top_out[i*DW +: DW]);
                end
            end
            if (checkPe && c == BUSY_LEN) begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        expAcc = 0;
                        for (int k = 0; k < N; k++) expAcc += refA[i][k] * refB[k][j];
                        testsRun++;
                        if (peAcc[i][j] !== expAcc) begin
                            testsFailed++;
                            $display("[TB] FAIL pe(%0d,%0d) result got %0d expected %0d", i, j, peAcc[i][j], expAcc);
                        end
                    end
                end
            end
            if (injWrite && c == 3) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = 8'd99;
            end
            if (injWrite && c == 4) wr_en = 1'b0;
            if (injStart && c == 5) start = 1'b1;
            if (injStart && c == 6) start = 1'b0;
            tick();
        end
        gotCtl = {acc_clr, busy, done};
        testsRun++;
        if (gotCtl !== 3'b000 || left_out !== '0 || top_out !== '0) begin
            testsFailed++;
            $display("[TB] FAIL idle after done: ctl %b left %h top %h expected all 0", gotCtl, left_out, top_out);
        end
        testsRun++;
        if (busyCount - busyStart != BUSY_LEN) begin
            testsFailed++;
            $display("[TB] FAIL busy width got %0d expected %0d", busyCount - busyStart, BUSY_LEN);
        end
        testsRun++;
        if (doneCount - doneStart != 1) begin
            testsFailed++;
            $display("[TB] FAIL done pulses got %0d expected 1", doneCount - doneStart);
        end
    endtask

    task automatic load_skew();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) write_elem(1'b0, i, k, 4 * i + k + 1);
        for (int k = 0; k < N; k++)
            for (int j = 0; j < N; j++) write_elem(1'b1, k, j, 10 * k + j + 1);
    endtask

    task automatic test_reset();
        int doneStart;
        doneStart = doneCount;
        rst = 1'b1; start = 1'b1; wr_en = 1'b0; wr_sel = 1'b0;
        wr_row = '0; wr_col = '0; wr_data = '0;
        clear_model();
        for (int n = 0; n < 2; n++) begin
            tick();
            testsRun++;
            if ({acc_clr, busy, done} !== 3'b000 || left_out !== '0 || top_out !== '0) begin
                testsFailed++;
                $display("[TB] FAIL reset cycle %0d: ctl %b left %h top %h expected all 0",
                         n, {acc_clr, busy, done}, left_out, top_out);
            end
        end
        rst = 1'b0; start = 1'b0;
        tick();
        testsRun++;
        if (busy !== 1'b0 || doneCount != doneStart) begin
            testsFailed++;
            $display("[TB] FAIL reset release: busy %b done pulses %0d expected 0/0", busy, doneCount - doneStart);
        end
    endtask

    task automatic test_skew();
        int expSk [3][2][N];
        int ts [3];
        bit bad;
        ts = '{0, 3, 6};
        expSk = '{ '{'{1, 0, 0, 0},   '{1, 0, 0, 0}},
                   '{'{4, 7, 10, 13}, '{31, 22, 13, 4}},
                   '{'{0, 0, 0, 16},  '{0, 0, 0, 34}} };
        load_skew();
        start = 1'b1;
        tick();
        check_product(1'b0, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < 3; s++) begin
            for (int side = 0; side < 2; side++) begin
                bad = 1'b0;
                for (int l = 0; l < N; l++)
                    if ((side == 0 ? capLeft[ts[s]][l] : capTop[ts[s]][l]) != expSk[s][side][l]) bad = 1'b1;
                testsRun++;
                if (bad) begin
                    testsFailed++;
                    $display("[TB] FAIL skew t=%0d %s: got %0d,%0d,%0d,%0d expected %0d,%0d,%0d,%0d",
                             ts[s], side == 0 ? "left" : "top",
                             side == 0 ? capLeft[ts[s]][0] : capTop[ts[s]][0],
                             side == 0 ? capLeft[ts[s]][1] : capTop[ts[s]][1],
                             side == 0 ? capLeft[ts[s]][2] : capTop[ts[s]][2],
                             side == 0 ? capLeft[ts[s]][3] : capTop[ts[s]][3],
                             expSk[s][side][0], expSk[s][side][1], expSk[s][side][2], expSk[s][side][3]);
                end
            end
        end
    endtask

    task automatic test_end_to_end();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) write_elem(1'b0, i, k, (i == k) ? 1 : 0);
        start = 1'b1;
        tick();
        check_product(1'b0, 1'b0, 1'b0, 1'b1);
        testsRun++;
        if (peAcc[2][1] != 22) begin
            testsFailed++;
            $display("[TB] FAIL pe(2,1) identity result got %0d expected 22", peAcc[2][1]);
        end
    endtask

    task automatic test_busy_window();
        start = 1'b1;
        tick();
        check_product(1'b1, 1'b1, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        check_product(1'b0, 1'b0, 1'b0, 1'b0);
        testsRun++;
        if (capLeft[0][0] != 1) begin
            testsFailed++;
            $display("[TB] FAIL write while busy: lane0 t=0 got %0d expected 1", capLeft[0][0]);
        end
    endtask

    task automatic test_reset_mid_feed();
        int doneStart;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 3; n++) tick();
        doneStart = doneCount;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        testsRun++;
        if ({acc_clr, busy, done} !== 3'b000 || left_out !== '0 || top_out !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset mid-feed: ctl %b left %h top %h expected all 0",
                     {acc_clr, busy, done}, left_out, top_out);
        end
        testsRun++;
        if (doneCount != doneStart) begin
            testsFailed++;
            $display("[TB] FAIL reset mid-feed done pulses got %0d expected 0", doneCount - doneStart);
        end
        start = 1'b1;
        tick();
        check_product(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int iter = 0; iter < 3; iter++) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    write_elem(1'b1, i, j, int'($urandom_range(0, 255)));
                    if (!(i == N - 1 && j == N - 1))
                        write_elem(1'b0, i, j, int'($urandom_range(0, 255)));
                end
            // Last A element written in the same cycle as start.
            wr_en = 1'b1; wr_sel = 1'b0; wr_row = IW'(N - 1); wr_col = IW'(N - 1);
            wr_data = DW'($urandom_range(0, 255));
            refA[N-1][N-1] = int'(wr_data);
            start = 1'b1;
            tick();
            wr_en = 1'b0;
            check_product(1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = doneTimes.size();
        start = 1'b1;
        tick();
        check_product(1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check_product(1'b0, 1'b0, 1'b0, 1'b1);
        testsRun++;
        if (doneTimes.size() != n0 + 2) begin
            testsFailed++;
            $display("[TB] FAIL back-to-back done count got %0d expected 2", doneTimes.size() - n0);
        end else if (doneTimes[n0+1] - doneTimes[n0] != 14) begin
            testsFailed++;
            $display("[TB] FAIL back-to-back done spacing got %0d expected 14", doneTimes[n0+1] - doneTimes[n0]);
        end
    endtask

    initial begin
        test_reset();
        test_skew();
        test_end_to_end();
        test_busy_window();
        test_reset_mid_feed();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
